// File: rtl/iir_coeff_sequencer.sv
// Run-time controller for the 3-tap stereo IIR filter: strobe generation, shadow
// coefficient bank, and atomic commit at a sample boundary followed by a filter flush.
module iir_coeff_sequencer #(
    parameter int CE_DIV       = 1024,
    parameter int STEREO       = 1,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  cfg_addr,
    input  logic [39:0] cfg_data,
    input  logic        cfg_wr,
    input  logic        cfg_commit,
    output logic        cfg_busy,
    output logic        commit_done,
    output logic        filt_ce,
    output logic        filt_sample_ce,
    output logic        filt_reset,
    output logic [39:0] cx,
    output logic [7:0]  cx0,
    output logic [7:0]  cx1,
    output logic [7:0]  cx2,
    output logic [23:0] cy0,
    output logic [23:0] cy1,
    output logic [23:0] cy2
);

    localparam int CNT_W = $clog2(CE_DIV);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   flush_cnt_r, flush_cnt_s;
    logic               phase_r;
    logic               filt_ce_r, filt_sample_ce_r, filt_reset_r;
    logic               cfg_busy_r, commit_done_r;
    logic               flush_s, ce_s, phase_s, sample_ce_s, wr_en_s, load_s, done_s;

    logic [39:0] sh_cx_r,  act_cx_r;
    logic [7:0]  sh_cx0_r, sh_cx1_r, sh_cx2_r, act_cx0_r, act_cx1_r, act_cx2_r;
    logic [23:0] sh_cy0_r, sh_cy1_r, sh_cy2_r, act_cy0_r, act_cy1_r, act_cy2_r;

    // Next-state and flush counting for the commit sequence
    always_comb begin
        state_s     = state_r;
        flush_cnt_s = flush_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (cfg_commit) begin
                    state_s = ST_PEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (filt_sample_ce_r) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_PEND;
                end
            end
            ST_LOAD: begin
                // flush_cnt holds the index of the current filt_reset cycle; LOAD is index 0
                flush_cnt_s = CNT_W'(1);
                if (FLUSH_CYCLES == 1) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r == CNT_W'(FLUSH_CYCLES - 1)) begin
                    state_s = ST_IDLE;
                end else begin
                    flush_cnt_s = flush_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Look-ahead values so every strobe leaves the block from a flop
    always_comb begin
        flush_s     = (state_s == ST_LOAD) || (state_s == ST_FLUSH);
        ce_s        = (cnt_r == CNT_W'(CE_DIV - 2)) && !flush_s;
        phase_s     = phase_r ^ filt_ce_r;
        sample_ce_s = ce_s && ((STEREO == 0) || phase_s);
        wr_en_s     = cfg_wr && (state_r == ST_IDLE);
        load_s      = (state_r == ST_PEND) && (state_s == ST_LOAD);
        done_s      = ((state_r == ST_LOAD) || (state_r == ST_FLUSH)) && (state_s == ST_IDLE);
    end

    // Control, counter and strobe registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            cnt_r            <= '0;
            flush_cnt_r      <= '0;
            phase_r          <= 1'b0;
            filt_ce_r        <= 1'b0;
            filt_sample_ce_r <= 1'b0;
            filt_reset_r     <= 1'b1;
            cfg_busy_r       <= 1'b0;
            commit_done_r    <= 1'b0;
        end else begin
            state_r          <= state_s;
            cnt_r            <= (cnt_r == CNT_W'(CE_DIV - 1)) ? '0 : cnt_r + CNT_W'(1);
            flush_cnt_r      <= flush_cnt_s;
            phase_r          <= phase_s;
            filt_ce_r        <= ce_s;
            filt_sample_ce_r <= sample_ce_s;
            filt_reset_r     <= flush_s;
            cfg_busy_r       <= (state_s != ST_IDLE);
            commit_done_r    <= done_s;
        end
    end

    // Shadow bank: written only while idle, narrow registers keep the low data bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_cx_r  <= 40'd0;
            sh_cx0_r <= 8'd0;
            sh_cx1_r <= 8'd0;
            sh_cx2_r <= 8'd0;
            sh_cy0_r <= 24'd0;
            sh_cy1_r <= 24'd0;
            sh_cy2_r <= 24'd0;
        end else if (wr_en_s) begin
            case (cfg_addr)
                3'd0:    sh_cx_r  <= cfg_data;
                3'd1:    sh_cx0_r <= cfg_data[7:0];
                3'd2:    sh_cx1_r <= cfg_data[7:0];
                3'd3:    sh_cx2_r <= cfg_data[7:0];
                3'd4:    sh_cy0_r <= cfg_data[23:0];
                3'd5:    sh_cy1_r <= cfg_data[23:0];
                3'd6:    sh_cy2_r <= cfg_data[23:0];
                default: sh_cx_r  <= sh_cx_r;
            endcase
        end
    end

    // Active bank: all seven coefficients move together on entry to LOAD
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_cx_r  <= 40'd0;
            act_cx0_r <= 8'd0;
            act_cx1_r <= 8'd0;
            act_cx2_r <= 8'd0;
            act_cy0_r <= 24'd0;
            act_cy1_r <= 24'd0;
            act_cy2_r <= 24'd0;
        end else if (load_s) begin
            act_cx_r  <= sh_cx_r;
            act_cx0_r <= sh_cx0_r;
            act_cx1_r <= sh_cx1_r;
            act_cx2_r <= sh_cx2_r;
            act_cy0_r <= sh_cy0_r;
            act_cy1_r <= sh_cy1_r;
            act_cy2_r <= sh_cy2_r;
        end
    end

    assign cfg_busy       = cfg_busy_r;
    assign commit_done    = commit_done_r;
    assign filt_ce        = filt_ce_r;
    assign filt_sample_ce = filt_sample_ce_r;
    assign filt_reset     = filt_reset_r;
    assign cx             = act_cx_r;
    assign cx0            = act_cx0_r;
    assign cx1            = act_cx1_r;
    assign cx2            = act_cx2_r;
    assign cy0            = act_cy0_r;
    assign cy1            = act_cy1_r;
    assign cy2            = act_cy2_r;

endmodule
